// File: rtl/rtc_bcd_timekeeper.sv
// rtl/rtc_bcd_timekeeper.sv - BCD 24 h timekeeper driven by a sampled slow clock.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_bcd_timekeeper #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        cristal_i,
  input  logic        RST_rst_i,
  input  logic        CLK_clk_i,
  input  logic        run_i,
  input  logic        load_i,
  input  logic [23:0] time_i,
  output logic [7:0]  sec_o,
  output logic [7:0]  min_o,
  output logic [7:0]  hour_o,
  output logic        sec_pulse_o,
  output logic        day_pulse_o,
  output logic        load_err_o,
  input  logic [23:0] alarm_i,
  input  logic        alarm_ack_i,
  output logic        alarm_o
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  state_t          r_state;
  logic            r_s1, r_s2, r_s3;
  logic [PW-1:0]   r_presc;
  logic            w_tick, w_count, w_valid, w_upd, w_day;
  logic [7:0]      w_sec_nx, w_min_nx, w_hour_nx;

  assign w_tick  = r_s2 & ~r_s3;
  assign w_count = w_tick && (r_state == ST_RUN) && !load_i;
  assign w_upd   = (load_i && w_valid) || (w_count && (r_presc == PMAX));

  assign w_valid = (time_i[3:0]   <= 4'd9) && (time_i[7:4]   <= 4'd5) &&
                   (time_i[11:8]  <= 4'd9) && (time_i[15:12] <= 4'd5) &&
                   (time_i[19:16] <= 4'd9) &&
                   ((time_i[23:20] < 4'd2) ||
                    ((time_i[23:20] == 4'd2) && (time_i[19:16] <= 4'd3)));

  // Ripple carry through the BCD digits, one second forward.
  always_comb begin
    w_sec_nx  = sec_o;
    w_min_nx  = min_o;
    w_hour_nx = hour_o;
    w_day     = 1'b0;
    if (sec_o[3:0] != 4'd9) begin
      w_sec_nx[3:0] = sec_o[3:0] + 4'd1;
    end else if (sec_o[7:4] != 4'd5) begin
      w_sec_nx = {sec_o[7:4] + 4'd1, 4'd0};
    end else begin
      w_sec_nx = 8'h00;
      if (min_o[3:0] != 4'd9) begin
        w_min_nx[3:0] = min_o[3:0] + 4'd1;
      end else if (min_o[7:4] != 4'd5) begin
        w_min_nx = {min_o[7:4] + 4'd1, 4'd0};
      end else begin
        w_min_nx = 8'h00;
        if (hour_o == 8'h23) begin
          w_hour_nx = 8'h00;
          w_day     = 1'b1;
        end else if (hour_o[3:0] != 4'd9) begin
          w_hour_nx[3:0] = hour_o[3:0] + 4'd1;
        end else begin
          w_hour_nx = {hour_o[7:4] + 4'd1, 4'd0};
        end
      end
    end
  end

  always_ff @(posedge cristal_i or posedge RST_rst_i) begin
    if (RST_rst_i) begin
      r_state     <= ST_STOP;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_presc     <= '0;
      sec_o       <= 8'h00;
      min_o       <= 8'h00;
      hour_o      <= 8'h00;
      sec_pulse_o <= 1'b0;
      day_pulse_o <= 1'b0;
      load_err_o  <= 1'b0;
    end else begin
      r_s1        <= CLK_clk_i;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_state     <= run_i ? ST_RUN : ST_STOP;
      sec_pulse_o <= 1'b0;
      day_pulse_o <= 1'b0;
      load_err_o  <= 1'b0;
      if (load_i) begin
        if (w_valid) begin
          {hour_o, min_o, sec_o} <= time_i;
          r_presc                <= '0;
        end else begin
          load_err_o <= 1'b1;
        end
      end else if (w_count) begin
        if (r_presc == PMAX) begin
          r_presc     <= '0;
          sec_o       <= w_sec_nx;
          min_o       <= w_min_nx;
          hour_o      <= w_hour_nx;
          sec_pulse_o <= 1'b1;
          day_pulse_o <= w_day;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic r_cmp;

  // Compare one cycle after the time register settles; ack overrides a match.
  always_ff @(posedge cristal_i or posedge RST_rst_i) begin
    if (RST_rst_i) begin
      r_cmp   <= 1'b0;
      alarm_o <= 1'b0;
    end else begin
      r_cmp <= w_upd;
      if (alarm_ack_i) begin
        alarm_o <= 1'b0;
      end else if (r_cmp && ({hour_o, min_o, sec_o} == alarm_i)) begin
        alarm_o <= 1'b1;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{alarm_i, alarm_ack_i, w_upd};
  assign alarm_o  = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bcd_timekeeper.sv
// tb/tb_rtc_bcd_timekeeper.sv - self-checking bench for rtc_bcd_timekeeper (TICKS_PER_SEC=4)
module tb_rtc_bcd_timekeeper;
  localparam int TPS = 4;

  logic        clk = 1'b0, rst = 1'b1, slow = 1'b0, run = 1'b0, load = 1'b0, ack = 1'b0;
  logic [23:0] tin = 24'h0, alarm = 24'h999999;
  logic [7:0]  sec, min, hour;
  logic        sp, dp, le, al;

  rtc_bcd_timekeeper #(.TICKS_PER_SEC(TPS)) dut (
    .cristal_i(clk), .RST_rst_i(rst), .CLK_clk_i(slow), .run_i(run),
    .load_i(load), .time_i(tin), .sec_o(sec), .min_o(min), .hour_o(hour),
    .sec_pulse_o(sp), .day_pulse_o(dp), .load_err_o(le),
    .alarm_i(alarm), .alarm_ack_i(ack), .alarm_o(al)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int n_sp = 0, n_dp = 0, n_both = 0, n_le = 0;
  int e_sp = 0, e_dp = 0, e_both = 0, e_le = 0;
  int m_secs = 0, m_presc = 0;
  bit m_run = 1'b0;

  always @(negedge clk) begin
    if (sp) n_sp++;
    if (dp) n_dp++;
    if (sp && dp) n_both++;
    if (le) n_le++;
  end

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [23:0] exp_time();
    return {bcd(m_secs / 3600), bcd((m_secs / 60) % 60), bcd(m_secs % 60)};
  endfunction

  function automatic bit valid(logic [23:0] t);
    for (int i = 0; i < 6; i++)
      if (t[i*4 +: 4] > 4'd9) return 1'b0;
    return (t[7:4] * 10 + t[3:0] < 60) && (t[15:12] * 10 + t[11:8] < 60) &&
           (t[23:20] * 10 + t[19:16] < 24);
  endfunction

  function automatic int to_secs(logic [23:0] t);
    return (t[23:20] * 10 + t[19:16]) * 3600 + (t[15:12] * 10 + t[11:8]) * 60 +
           (t[7:4] * 10 + t[3:0]);
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rise(int n);
    repeat (n) begin
      slow = 1'b1; cyc(4);
      slow = 1'b0; cyc(4);
      if (m_run) begin
        m_presc++;
        if (m_presc == TPS) begin
          m_presc = 0;
          m_secs  = (m_secs + 1) % 86400;
          e_sp++;
          if (m_secs == 0) begin e_dp++; e_both++; end
        end
      end
    end
  endtask

  task automatic do_load(logic [23:0] v);
    load = 1'b1; tin = v; cyc(1);
    load = 1'b0; cyc(2);
    if (valid(v)) begin m_secs = to_secs(v); m_presc = 0; end
    else e_le++;
  endtask

  task automatic set_run(bit r);
    run = r; cyc(2);
    m_run = r;
  endtask

  task automatic check_all(string tag);
    chk({tag, "_time"}, {8'h0, hour, min, sec}, {8'h0, exp_time()});
    chk({tag, "_secpulses"}, n_sp, e_sp);
    chk({tag, "_daypulses"}, n_dp, e_dp);
    chk({tag, "_loaderrs"}, n_le, e_le);
  endtask

  initial begin
    cyc(3);
    chk("reset_time", {8'h0, hour, min, sec}, 32'h0);
    chk("reset_pulses", {29'h0, sp, dp, le}, 32'h0);
    chk("reset_alarm", {31'h0, al}, 32'h0);
    rst = 1'b0; cyc(2);

    set_run(1'b1);
    rise(4); check_all("one_sec");
    chk("one_sec_value", {24'h0, sec}, 32'h01);
    rise(3); check_all("three_rises");

    do_load(24'h235959);
    rise(4); check_all("day_wrap");
    chk("day_wrap_both", n_both, e_both);
    chk("day_wrap_count", n_both, 1);

    do_load(24'h126A00); check_all("bad_nibble");
    do_load(24'h240000); check_all("bad_hour");

    do_load(24'h000000);
    rise(2); set_run(1'b0); rise(5); set_run(1'b1); rise(2);
    check_all("stop_hold");
    chk("stop_hold_value", {8'h0, hour, min, sec}, 32'h000001);

    // Load lands in the same cycle as a tick; the tick must be dropped.
    slow = 1'b1; cyc(2);
    load = 1'b1; tin = 24'h101010; cyc(1);
    load = 1'b0; cyc(2);
    slow = 1'b0; cyc(4);
    m_secs = to_secs(24'h101010); m_presc = 0;
    check_all("load_tick");
    rise(3); check_all("load_tick_presc");
    rise(1); check_all("load_tick_sec");

    rise(2);
    @(posedge clk); #3 rst = 1'b1; #1;
    chk("async_reset_time", {8'h0, hour, min, sec}, 32'h0);
    chk("async_reset_pulses", {29'h0, sp, dp, le}, 32'h0);
    cyc(2); rst = 1'b0; cyc(2);
    m_secs = 0; m_presc = 0;
    rise(4); check_all("after_reset");

    for (int i = 0; i < 10; i++) begin
      case ($urandom_range(0, 3))
        0: do_load({bcd($urandom_range(0, 23)), bcd($urandom_range(0, 59)),
                    bcd($urandom_range(0, 59))});
        1: set_run(~m_run);
        2: do_load(24'($urandom));
        default: ;
      endcase
      rise($urandom_range(0, 9));
      check_all($sformatf("rand%0d", i));
    end

`ifdef RTC_ALARM_EN
    set_run(1'b1);
    alarm = 24'h000003;
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
    do_load(24'h000000);
    rise(12); check_all("alarm_run");
    chk("alarm_set", {31'h0, al}, 32'h1);
    rise(2);
    chk("alarm_held", {31'h0, al}, 32'h1);
    ack = 1'b1; cyc(1); ack = 1'b0; cyc(1);
    chk("alarm_ack", {31'h0, al}, 32'h0);
`else
    alarm = 24'h000000;
    do_load(24'h000000);
    rise(2);
    chk("alarm_disabled", {31'h0, al}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
